// File: rtl/mtf_encoder.sv
// Move-to-front encoder for one BWT block: captures the last column and primary index,
// then ranks each symbol against a 256-entry recency table, one table entry per cycle.
`timescale 1ns/1ps
module mtf_encoder #(
  parameter int STRING_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*STRING_LEN-1:0] bwt_string,
  input  logic [8*STRING_LEN-1:0] suffixes_in,
  input  logic                    bwt_valid,
  output logic [7:0]              mtf_data,
  output logic                    mtf_valid,
  input  logic                    mtf_ready,
  output logic                    mtf_last,
  output logic [7:0]              primary_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(STRING_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tbl_q [256];
  logic [7:0]      str_q [STRING_LEN];
  logic [CW-1:0]   sym_ctr_q, sym_ctr_d;
  logic [CW-1:0]   next_ctr;
  logic [7:0]      scan_idx_q, scan_idx_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      pidx_q, pidx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            capture;
  logic            tbl_we;
  logic [7:0]      pidx_search;
  logic [7:0]      cur_sym;
  logic [7:0]      tbl_rd;

  // Lowest row whose suffix starts at position 0; downward scan lets the lowest win.
  always_comb begin
    pidx_search = 8'hFF;
    for (int r = STRING_LEN - 1; r >= 0; r--) begin
      if (suffixes_in[8*r +: 8] == 8'h00) pidx_search = 8'(r);
    end
  end

  assign next_ctr = sym_ctr_q + CW'(1);
  assign cur_sym  = str_q[sym_ctr_q];
  assign tbl_rd   = tbl_q[scan_idx_q];

  always_comb begin
    state_d    = state_q;
    sym_ctr_d  = sym_ctr_q;
    scan_idx_d = scan_idx_q;
    hold_d     = hold_q;
    data_d     = data_q;
    pidx_d     = pidx_q;
    valid_d    = valid_q;
    last_d     = last_q;
    capture    = 1'b0;
    tbl_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bwt_valid) begin
          capture    = 1'b1;
          pidx_d     = pidx_search;
          sym_ctr_d  = '0;
          scan_idx_d = 8'h00;
          hold_d     = bwt_string[7:0];
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        // Every probed slot takes the carried value, rippling the prefix up by one.
        tbl_we = 1'b1;
        if (tbl_rd == cur_sym) begin
          data_d  = scan_idx_q;
          valid_d = 1'b1;
          last_d  = (sym_ctr_q == LAST_IDX);
          state_d = EMIT;
        end else begin
          hold_d     = tbl_rd;
          scan_idx_d = scan_idx_q + 8'h01;
        end
      end
      EMIT: begin
        if (mtf_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            sym_ctr_d  = next_ctr;
            scan_idx_d = 8'h00;
            hold_d     = str_q[next_ctr];
            state_d    = SEARCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sym_ctr_q  <= '0;
      scan_idx_q <= 8'h00;
      hold_q     <= 8'h00;
      data_q     <= 8'h00;
      pidx_q     <= 8'hFF;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_ctr_q  <= sym_ctr_d;
      scan_idx_q <= scan_idx_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      pidx_q     <= pidx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || capture) begin
      for (int i = 0; i < 256; i++) tbl_q[i] <= 8'(i);
    end else if (tbl_we) begin
      tbl_q[scan_idx_q] <= hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < STRING_LEN; i++) str_q[i] <= bwt_string[8*i +: 8];
    end
  end

  assign mtf_data    = data_q;
  assign mtf_valid   = valid_q;
  assign mtf_last    = last_q;
  assign primary_idx = pidx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mtf_encoder.sv
// Scoreboard bench for mtf_encoder: directed blocks push hand-computed ranks,
// a negedge monitor pops and compares on every accepted transfer.
`timescale 1ns/1ps
module tb_mtf_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] bwt_string;
  logic [63:0] suffixes_in;
  logic        bwt_valid;
  logic [7:0]  mtf_data;
  logic        mtf_valid;
  logic        mtf_ready;
  logic        mtf_last;
  logic [7:0]  primary_idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int cap_cyc  = 0;
  int first_valid_cyc = 0;
  bit seen_valid = 1'b0;
  logic [8:0] exp_q[$];
  int xfer_q[$];

  mtf_encoder #(.STRING_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .bwt_string(bwt_string), .suffixes_in(suffixes_in),
    .bwt_valid(bwt_valid), .mtf_data(mtf_data), .mtf_valid(mtf_valid),
    .mtf_ready(mtf_ready), .mtf_last(mtf_last), .primary_idx(primary_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every accepted transfer against the scoreboard head.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && mtf_valid) begin
      if (!seen_valid) begin
        seen_valid = 1'b1;
        first_valid_cyc = cyc;
      end
      if (mtf_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rank[%0d]", xfer_q.size()), mtf_data, int'(e[7:0]));
          chk($sformatf("last[%0d]", xfer_q.size()), mtf_last, int'(e[8]));
        end
        xfer_q.push_back(cyc);
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_ranks(input int r[8], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 7), 8'(r[i])});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", mtf_valid, 0);
    chk("rst_last", mtf_last, 0);
    chk("rst_data", mtf_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_primary", primary_idx, 8'hFF);
    rst_n = 1'b1;
  endtask

  // Called at #1 after an edge; bwt_valid is high for exactly the next cycle.
  task automatic start_block(input logic [63:0] s, input logic [63:0] p, input int exp_pidx);
    bwt_string  = s;
    suffixes_in = p;
    bwt_valid   = 1'b1;
    xfer_q.delete();
    seen_valid  = 1'b0;
    @(posedge clk);
    #1;
    cap_cyc   = cyc;
    bwt_valid = 1'b0;
    chk("primary_idx", primary_idx, exp_pidx);
    chk("busy_after_capture", busy, 1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (xfer_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("xfer_wait_timeout", (xfer_q.size() < n) ? 1 : 0, 0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    int start = done_cnt;
    while (done_cnt == start && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_done_timeout"}, (done_cnt == start) ? 1 : 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_done_pulses"}, done_cnt - start, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int r_aab[8]  = '{65, 0, 66, 0, 0, 1, 0, 0};
    int r_zero[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int r_abc[8]  = '{65, 66, 67, 2, 2, 2, 2, 2};
    int r_rst[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    int r_new[8]  = '{5, 0, 65, 1, 2, 0, 2, 255};
    int k;
    rst_n = 1'b0;
    bwt_valid = 1'b0;
    mtf_ready = 1'b1;
    bwt_string = '0;
    suffixes_in = '0;
    do_reset();

    // "AABBBAAA", suffix 0 at row 1; A sits 65 deep, so 66 SEARCH cycles first.
    push_ranks(r_aab, 8);
    start_block(64'h41_41_41_42_42_42_41_41, 64'h07_06_05_04_02_01_00_03, 1);
    wait_done(2000, "aab");
    chk("first_latency", first_valid_cyc - cap_cyc, 66);
    chk("aab_count", xfer_q.size(), 8);

    // All zero symbols: one SEARCH plus one EMIT per symbol.
    push_ranks(r_zero, 8);
    start_block(64'h0, 64'h00_07_06_05_04_03_02_01, 7);
    wait_done(200, "zero");
    chk("min_latency", first_valid_cyc - cap_cyc, 1);
    for (int i = 1; i < xfer_q.size(); i++)
      chk($sformatf("zero_gap[%0d]", i), xfer_q[i] - xfer_q[i-1], 2);

    // Backpressure on the third symbol for 10 cycles.
    push_ranks(r_abc, 8);
    start_block(64'h42_41_43_42_41_43_42_41, 64'h02_04_07_01_06_00_03_05, 2);
    wait_xfers(2, 500);
    mtf_ready = 1'b0;
    k = 0;
    while (!mtf_valid && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("bp_valid_timeout", mtf_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", mtf_valid, 1);
      chk("bp_data_held", mtf_data, 67);
    end
    chk("bp_no_transfer", xfer_q.size(), 2);
    mtf_ready = 1'b1;
    wait_done(2000, "abc");

    // Second bwt_valid mid-block must be ignored.
    push_ranks(r_aab, 8);
    start_block(64'h41_41_41_42_42_42_41_41, 64'h07_06_05_04_02_01_00_03, 1);
    wait_xfers(3, 2000);
    bwt_string  = 64'hFFFF_FFFF_FFFF_FFFF;
    suffixes_in = 64'h0;
    bwt_valid   = 1'b1;
    @(posedge clk);
    #1;
    bwt_valid = 1'b0;
    wait_done(2000, "ignore");
    chk("ignore_primary", primary_idx, 1);

    // Reset while symbol 4 (0xF0, 241 probes) is still searching.
    push_ranks(r_rst, 3);
    start_block(64'h00_00_00_00_F0_00_00_00, 64'h07_06_05_04_03_02_01_00, 0);
    wait_xfers(3, 200);
    repeat (20) @(posedge clk);
    #1;
    chk("midsearch_busy", busy, 1);
    chk("midsearch_valid", mtf_valid, 0);
    do_reset();
    chk("reset_queue_empty", exp_q.size(), 0);
    push_ranks(r_new, 8);
    start_block(64'hFF_41_00_00_05_41_05_05, 64'h08_07_06_05_04_03_02_01, 8'hFF);
    wait_done(3000, "post_reset");
    chk("post_reset_primary", primary_idx, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mtf_encoder.md
MTF_ENCODER -- requirements
Module: mtf_encoder

Interface
REQ-001: Parameter STRING_LEN, default 8, is the number of BWT symbols per block, legal range 1..255.
REQ-002: clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  is a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004: bwt_string  input  8 x STRING_LEN  is the BWT last column from the suffix sorter (output_string), element 0 first.
REQ-005: suffixes_in  input  8 x STRING_LEN  is the sorted suffix array from the sorter (suffixes_out).
REQ-006: bwt_valid  input  1  is the sorter done pulse; bwt_string and suffixes_in are valid in that cycle.
REQ-007: mtf_data  output  8  is the MTF rank of the current symbol.
REQ-008: mtf_valid  output  1  qualifies mtf_data and mtf_last.
REQ-009: mtf_ready  input  1  is the downstream accept; a transfer occurs when mtf_valid and mtf_ready are both 1.
REQ-010: mtf_last  output  1  marks the rank of symbol STRING_LEN-1.
REQ-011: primary_idx  output  8  is the row r with suffixes_in[r]==0, or 8'hFF if no such row.
REQ-012: busy  output  1  is high in every state except IDLE.
REQ-013: done  output  1  is a one-cycle pulse after the last transfer.

Function
REQ-014: The FSM SHALL have states IDLE, SEARCH, EMIT and DONE; all outputs SHALL be registered.
REQ-015: IDLE with bwt_valid=1 SHALL, in one cycle: latch bwt_string; latch primary_idx (lowest matching r); set table[i]=i for i=0..255; set sym_ctr=0, scan_idx=0, hold=bwt_string[0]; go to SEARCH.
REQ-016: bwt_valid SHALL be ignored outside IDLE.
REQ-017: Each SEARCH cycle SHALL examine table[scan_idx], with sym = latched symbol sym_ctr.
REQ-018: If table[scan_idx]==sym, the cycle SHALL write table[scan_idx]=hold, load mtf_data=scan_idx and go to EMIT.
REQ-019: Otherwise the cycle SHALL write table[scan_idx]=hold, load hold=old table[scan_idx] and increment scan_idx.
REQ-020: Net effect per symbol: the symbol moves to index 0 and entries 0..j-1 shift up by one, where j is its prior index.
REQ-021: A symbol at index j SHALL take j+1 SEARCH cycles; the table is always a permutation, so a match is guaranteed with scan_idx at most 255 and no wrap.
REQ-022: EMIT SHALL hold mtf_valid=1 with mtf_data stable; mtf_last=1 when sym_ctr==STRING_LEN-1.
REQ-023: EMIT without mtf_ready SHALL hold all state (backpressure for any duration).
REQ-024: On a transfer that is not the last, the FSM SHALL clear mtf_valid, increment sym_ctr, set scan_idx=0 and hold=next symbol, and go to SEARCH.
REQ-025: On the last transfer, the FSM SHALL clear mtf_valid and mtf_last and go to DONE.
REQ-026: DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-027: primary_idx SHALL remain stable from capture until the next capture.
REQ-028: Minimum latency from bwt_valid to the first mtf_valid SHALL be 2 cycles (capture cycle, then 1 SEARCH cycle for j=0).

Reset
REQ-029: rst_n=0 SHALL, in any state including mid-SEARCH or mid-EMIT, force: IDLE; mtf_valid=0, mtf_last=0, mtf_data=0, done=0, busy=0, primary_idx=8'hFF; table[i]=i; all counters 0.
REQ-030: The first cycle after reset is released SHALL accept bwt_valid.

Verification
REQ-031: Reset, then bwt_string="AABBBAAA" (41 41 42 42 42 41 41 41), suffixes_in={3,0,...}, mtf_ready=1 -> ranks 65,0,66,0,0,1,0,0; mtf_last only on the 8th; primary_idx=1; one done pulse.
REQ-032: Same stimulus -> first mtf_valid exactly 67 cycles after the bwt_valid cycle (capture + 66 SEARCH cycles).
REQ-033: bwt_string all 8'h00 -> ranks all 0, each 2 cycles apart with ready=1.
REQ-034: Hold mtf_ready=0 for 10 cycles on the 3rd symbol -> mtf_data and mtf_valid stay stable, no symbol is lost, and the sequence is unchanged.
REQ-035: Pulse bwt_valid again mid-block -> ignored; output identical to the undisturbed run.
REQ-036: rst_n=0 during SEARCH of symbol 4, then a new block -> outputs cleared and the new block's ranks are computed from the identity table; suffixes_in with no zero -> primary_idx=8'hFF.
